// File: rtl/master_i2c_controller.sv
// Single-master I2C byte engine: START, address byte, one data byte (write or
// single-byte read with master NACK), STOP. SDA is open-drain; SCL is push-pull.
module master_i2c_controller #(
    parameter int CLK_DIV = 4
) (
    input  logic       master_fpga_clk,
    input  logic       master_reset,
    input  logic       master_start,
    input  logic [6:0] master_addr,
    input  logic       master_rd_wr,
    input  logic [7:0] master_data,
    output logic [7:0] master_data_out,
    output logic       master_busy,
    output logic       master_done,
    output logic       master_ack_err,
    output logic       master_scl,
    inout  wire        master_sda
);

    localparam int               CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_NACK,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [1:0]       qtr_q, qtr_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       tx_sh_q, tx_sh_d;
    logic [7:0]       rx_sh_q, rx_sh_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             rd_wr_q, rd_wr_d;
    logic             sda_smp_q, sda_smp_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ack_err_q, ack_err_d;
    logic             scl_q, scl_d;
    logic             sda_low_q, sda_low_d;

    logic             qtr_end;
    logic             bit_end;
    logic             smp_now;
    logic             sda_in;

    // Bus levels for a given state/quarter; returns {scl, sda_pull_low}.
    function automatic logic [1:0] line_drive(input state_t st, input logic [1:0] qtr,
                                              input logic tx_bit);
        logic scl_v;
        logic low_v;
        scl_v = qtr[1];
        low_v = 1'b0;
        case (st)
            IDLE: scl_v = 1'b1;
            START: begin
                scl_v = 1'b1;
                low_v = qtr[1];
            end
            ADDR, WR_DATA: low_v = ~tx_bit;
            STOP: low_v = (qtr != 2'd3);
            default: ;
        endcase
        return {scl_v, low_v};
    endfunction

    assign sda_in     = master_sda;
    assign master_sda = sda_low_q ? 1'b0 : 1'bz;

    assign qtr_end = (clk_cnt_q == CNT_LAST);
    assign bit_end = qtr_end && (qtr_q == 2'd3);
    assign smp_now = qtr_end && (qtr_q == 2'd2);

    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        qtr_d      = qtr_q;
        bit_cnt_d  = bit_cnt_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        wr_data_d  = wr_data_q;
        rd_wr_d    = rd_wr_q;
        sda_smp_d  = sda_smp_q;
        data_out_d = data_out_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ack_err_d  = ack_err_q;

        if (state_q != IDLE) begin
            clk_cnt_d = qtr_end ? '0 : clk_cnt_q + 1'b1;
            if (qtr_end) begin
                qtr_d = qtr_q + 2'd1;
            end
            if (smp_now) begin
                sda_smp_d = sda_in;
            end
        end

        case (state_q)
            IDLE: begin
                if (master_start) begin
                    state_d   = START;
                    tx_sh_d   = {master_addr, master_rd_wr};
                    wr_data_d = master_data;
                    rd_wr_d   = master_rd_wr;
                    rx_sh_d   = 8'h00;
                    ack_err_d = 1'b0;
                    busy_d    = 1'b1;
                    clk_cnt_d = '0;
                    qtr_d     = 2'd0;
                    bit_cnt_d = 4'd0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = ADDR;
                    bit_cnt_d = 4'd0;
                end
            end
            ADDR: begin
                if (bit_end) begin
                    if (bit_cnt_q == 4'd7) begin
                        state_d   = ADDR_ACK;
                        bit_cnt_d = 4'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        tx_sh_d   = {tx_sh_q[6:0], 1'b0};
                    end
                end
            end
            ADDR_ACK: begin
                // sda_smp_q holds the level captured at the end of q2 of this bit
                if (bit_end) begin
                    bit_cnt_d = 4'd0;
                    if (sda_smp_q) begin
                        ack_err_d = 1'b1;
                        state_d   = STOP;
                    end else if (rd_wr_q) begin
                        state_d = RD_DATA;
                    end else begin
                        state_d = WR_DATA;
                        tx_sh_d = wr_data_q;
                    end
                end
            end
            WR_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == 4'd7) begin
                        state_d   = WR_ACK;
                        bit_cnt_d = 4'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        tx_sh_d   = {tx_sh_q[6:0], 1'b0};
                    end
                end
            end
            WR_ACK: begin
                if (bit_end) begin
                    if (sda_smp_q) begin
                        ack_err_d = 1'b1;
                    end
                    state_d = STOP;
                end
            end
            RD_DATA: begin
                if (smp_now) begin
                    rx_sh_d = {rx_sh_q[6:0], sda_in};
                end
                if (bit_end) begin
                    if (bit_cnt_q == 4'd7) begin
                        state_d   = RD_NACK;
                        bit_cnt_d = 4'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            RD_NACK: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    if (rd_wr_q && !ack_err_q) begin
                        data_out_d = rx_sh_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Pins are registered from next-state so they never glitch on the bus
        {scl_d, sda_low_d} = line_drive(state_d, qtr_d, tx_sh_d[7]);
    end

    always_ff @(posedge master_fpga_clk or posedge master_reset) begin
        if (master_reset) begin
            state_q    <= IDLE;
            clk_cnt_q  <= '0;
            qtr_q      <= 2'd0;
            bit_cnt_q  <= 4'd0;
            tx_sh_q    <= 8'h00;
            rx_sh_q    <= 8'h00;
            wr_data_q  <= 8'h00;
            rd_wr_q    <= 1'b0;
            sda_smp_q  <= 1'b0;
            data_out_q <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            scl_q      <= 1'b1;
            sda_low_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            qtr_q      <= qtr_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            wr_data_q  <= wr_data_d;
            rd_wr_q    <= rd_wr_d;
            sda_smp_q  <= sda_smp_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ack_err_q  <= ack_err_d;
            scl_q      <= scl_d;
            sda_low_q  <= sda_low_d;
        end
    end

    assign master_data_out = data_out_q;
    assign master_busy     = busy_q;
    assign master_done     = done_q;
    assign master_ack_err  = ack_err_q;
    assign master_scl      = scl_q;

endmodule

// File: tb/tb_master_i2c_controller.sv
// Bench for master_i2c_controller: behavioural I2C slave on a pulled-up SDA,
// scoreboard of expected transaction outcomes checked at each done pulse.
module tb_master_i2c_controller;

    localparam int CD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:0] addr;
    logic       rd_wr;
    logic [7:0] data;
    logic [7:0] dout;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       scl;
    wire        sda;

    pullup (sda);

    logic       sl_low = 1'b0;
    assign sda = sl_low ? 1'b0 : 1'bz;

    master_i2c_controller #(.CLK_DIV(CD)) dut (
        .master_fpga_clk (clk),
        .master_reset    (rst),
        .master_start    (start),
        .master_addr     (addr),
        .master_rd_wr    (rd_wr),
        .master_data     (data),
        .master_data_out (dout),
        .master_busy     (busy),
        .master_done     (done),
        .master_ack_err  (ack_err),
        .master_scl      (scl),
        .master_sda      (sda)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int n_done = 0;
    int cyc    = 0;
    int t0     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Slave configuration, set by the stimulus before each transaction
    logic       sl_ack_addr = 1'b1;
    logic       sl_ack_data = 1'b1;
    logic       sl_rd       = 1'b0;
    logic [7:0] sl_rd_byte  = 8'h00;

    // Slave observations
    int         sl_cnt    = 0;
    logic       p_scl     = 1'b1;
    logic       p_sda     = 1'b1;
    logic       stop_seen = 1'b0;
    logic [7:0] cap_addr  = 8'h00;
    logic [7:0] cap_data  = 8'h00;
    logic       cap_ack2  = 1'b0;

    // Bus is sampled on the falling clk edge, where DUT pins are settled
    always @(negedge clk) begin
        int cnt;
        int nx;
        cnt = sl_cnt;
        if (p_scl && scl && p_sda && !sda) begin
            cnt = 0;
            stop_seen <= 1'b0;
        end
        if (p_scl && scl && !p_sda && sda) stop_seen <= 1'b1;
        if (!p_scl && scl) begin
            cnt = cnt + 1;
            if (cnt <= 8) cap_addr <= {cap_addr[6:0], sda};
            else if (cnt >= 10 && cnt <= 17) cap_data <= {cap_data[6:0], sda};
            else if (cnt == 18) cap_ack2 <= sda;
        end
        if (p_scl && !scl) begin
            nx = cnt + 1;
            if (nx == 9 && sl_ack_addr) sl_low <= 1'b1;
            else if (nx >= 10 && nx <= 17 && sl_rd && sl_ack_addr) sl_low <= ~sl_rd_byte[17 - nx];
            else if (nx == 18 && !sl_rd && sl_ack_addr && sl_ack_data) sl_low <= 1'b1;
            else sl_low <= 1'b0;
        end
        sl_cnt <= cnt;
        p_scl  <= scl;
        p_sda  <= sda;
    end

    typedef struct {
        logic [7:0] addr_byte;
        logic [7:0] wr_byte;
        logic       chk_wr;
        logic       chk_rd;
        logic       ack_err;
        logic [7:0] dout;
        int         lat;
        int         rises;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_dout = 8'h00;

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            n_done <= n_done + 1;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("latency", cyc - t0, e.lat);
                chk("ack_err", {31'd0, ack_err}, {31'd0, e.ack_err});
                chk("data_out", {24'd0, dout}, {24'd0, e.dout});
                chk("busy_at_done", {31'd0, busy}, 32'd0);
                chk("addr_byte", {24'd0, cap_addr}, {24'd0, e.addr_byte});
                chk("stop_seen", {31'd0, stop_seen}, 32'd1);
                chk("scl_rises", sl_cnt, e.rises);
                if (e.chk_wr) chk("wr_byte", {24'd0, cap_data}, {24'd0, e.wr_byte});
                if (e.chk_rd) chk("master_nack", {31'd0, cap_ack2}, 32'd1);
            end
        end
    end

    task automatic send(input logic [6:0] a, input logic rw, input logic [7:0] d,
                        input logic aa, input logic ad, input logic [7:0] rb);
        exp_t e;
        sl_ack_addr = aa;
        sl_ack_data = ad;
        sl_rd       = rw;
        sl_rd_byte  = rb;
        if (rw && aa) exp_dout = rb;
        e.addr_byte = {a, rw};
        e.wr_byte   = d;
        e.chk_wr    = !rw && aa;
        e.chk_rd    = rw && aa;
        e.ack_err   = !aa || (!rw && !ad);
        e.dout      = exp_dout;
        e.lat       = aa ? 80 * CD : 44 * CD;
        e.rises     = aa ? 19 : 10;
        exp_q.push_back(e);
        addr  = a;
        rd_wr = rw;
        data  = d;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        t0    = cyc;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("ack_err_cleared", {31'd0, ack_err}, 32'd0);
    endtask

    task automatic wait_done(input int maxc);
        int k;
        k = 0;
        while (!done && k < maxc) begin
            @(negedge clk);
            k++;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        addr  = 7'h00;
        rd_wr = 1'b0;
        data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_scl", {31'd0, scl}, 32'd1);
        chk("rst_sda", {31'd0, sda}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ack_err", {31'd0, ack_err}, 32'd0);
        chk("rst_data_out", {24'd0, dout}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Write with ACKs
        send(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00);
        wait_done(1000);
        repeat (5) @(negedge clk);

        // Single-byte read
        send(7'h2A, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C);
        wait_done(1000);
        repeat (5) @(negedge clk);

        // Address NACK on a read: no data phase, data_out holds
        send(7'h11, 1'b1, 8'h00, 1'b0, 1'b0, 8'hFF);
        wait_done(1000);
        repeat (5) @(negedge clk);

        // Write data NACK; ack_err must persist while idle
        send(7'h33, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h00);
        wait_done(1000);
        repeat (20) @(negedge clk);
        chk("ack_err_holds", {31'd0, ack_err}, 32'd1);

        // Next start clears ack_err; a start pulse while busy is ignored
        send(7'h40, 1'b0, 8'h0F, 1'b1, 1'b1, 8'h00);
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1000);
        repeat (50) @(negedge clk);
        chk("no_retrigger_busy", {31'd0, busy}, 32'd0);
        chk("queue_empty", exp_q.size(), 32'd0);

        // Reset during ADDR bit 3 (bit period 4: clocks 64..79 after accept)
        send(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00);
        repeat (70) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_scl", {31'd0, scl}, 32'd1);
        chk("mid_rst_sda", {31'd0, sda}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_data_out", {24'd0, dout}, 32'd0);
        exp_q.delete();
        exp_dout = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_idle_busy", {31'd0, busy}, 32'd0);

        send(7'h66, 1'b0, 8'hC3, 1'b1, 1'b1, 8'h00);
        wait_done(1000);
        repeat (5) @(negedge clk);

        chk("done_count", n_done, 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/master_i2c_controller.md
MASTER_I2C_CONTROLLER -- requirements
Module: master_i2c_controller

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning master_fpga_clk cycles per SCL quarter-period (legal range >=1).
REQ-002 SHALL have port master_fpga_clk  input  1  system clock; one clock, all state on its rising edge.
REQ-003 SHALL have port master_reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port master_start  input  1  transaction request, sampled only in IDLE.
REQ-005 SHALL have port master_addr  input  7  target slave address.
REQ-006 SHALL have port master_rd_wr  input  1  1=read, 0=write; sent as bit 0 of the address byte.
REQ-007 SHALL have port master_data  input  8  byte to write.
REQ-008 SHALL have port master_data_out  output  8  byte received on read.
REQ-009 SHALL have port master_busy  output  1  high from accepted start until done.
REQ-010 SHALL have port master_done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port master_ack_err  output  1  NACK seen in the last transaction.
REQ-012 SHALL have port master_scl  output  1  I2C clock.
REQ-013 SHALL have port master_sda  inout  1  I2C data, open-drain.

Function
REQ-014 SHALL drive master_sda only low or high-Z, never 1; bus pull-up supplies 1.
REQ-015 SHALL use FSM states IDLE, START, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_NACK, STOP.
REQ-016 SHALL divide every bit period into 4 quarters of CLK_DIV clocks: SCL low in q0-q1 and high in q2-q3; SDA changes only at q0 start; SDA sampled on the last clock of q2.
REQ-017 IDLE: SCL=1, SDA released, busy=0; master_start=1 latches addr, rd_wr and data, clears ack_err, sets busy next cycle, and enters START.
REQ-018 START (1 bit period): SCL high throughout; SDA released in q0-q1 and pulled low in q2-q3.
REQ-019 ADDR: 8 bits, MSB first, {addr[6:0], rd_wr}; ADDR_ACK: SDA released, sampled bit 0=ACK.
REQ-020 ADDR_ACK NACK SHALL set ack_err and go to STOP with no data phase.
REQ-021 WR_DATA: 8 data bits MSB first; WR_ACK samples; NACK sets ack_err; both outcomes go to STOP.
REQ-022 RD_DATA: SDA released; 8 sampled bits shifted MSB first; RD_NACK: SDA released for the 9th bit (master NACK, single-byte read).
REQ-023 STOP: SDA low in q0-q2 and released in q3; SCL low in q0-q1 and high in q2-q3.
REQ-024 After STOP q3: done=1 for one cycle, busy=0, return to IDLE; on a read with no ack_err, master_data_out updates in the same cycle, else it holds.
REQ-025 Latency from the clock edge sampling master_start to the done pulse: full transaction 80*CLK_DIV clocks; address-NACK 44*CLK_DIV clocks.
REQ-026 master_start while busy SHALL be ignored; held start re-triggers only after return to IDLE.
REQ-027 master_ack_err SHALL hold its value until the next accepted start.
REQ-028 Quarter and bit counters SHALL be sized for CLK_DIV and 9 bits with no wrap-around inside a phase.

Reset
REQ-029 On master_reset assertion, immediately and without a clock: state=IDLE, master_scl=1, master_sda high-Z, master_busy=0, master_done=0, master_ack_err=0, master_data_out=8'h00, all counters and shift registers 0.
REQ-030 Reset mid-transaction SHALL abort without STOP generation; the first start after release begins a fresh START.

Verification
REQ-031 Write, CLK_DIV=4, addr 7'h50, data 8'hA5, slave ACKs -> SDA bits 1010000_0, ACK, 10100101, ACK, STOP; done at clock 320; ack_err=0.
REQ-032 Read, addr 7'h2A, slave returns 8'h3C -> address byte 0101010_1, master releases 9th data bit; data_out=8'h3C at done (clock 320).
REQ-033 Address NACK (addr 7'h11, SDA left high) -> ack_err=1, STOP directly, done at clock 176, data_out unchanged.
REQ-034 Write data NACK -> ack_err=1 at done (clock 320); next accepted start clears it.
REQ-035 master_start pulsed at clock 100 of a busy transaction -> ignored, no second transaction, single done pulse.
REQ-036 master_reset asserted during ADDR bit 3 -> same cycle SCL=1, SDA high-Z, busy=0; a start after release produces a correct full write.
